// File: rtl/fft_ram_reader_if.sv
// RAM read port and output stream of the FFT buffer read-side sequencer.
// master = sequencer side, slave = RAM/downstream side.
interface fft_ram_reader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last
  );
endinterface

// File: rtl/fft_ram_reader.sv
// Read-side sequencer for the FFT dual-port RAM: issues one frame of addresses,
// absorbs the RAM read latency and streams words out with full backpressure.
module fft_ram_reader #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned BIT_REVERSE = 0
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  fft_ram_reader_if.master bus
);

  localparam int unsigned FIFO_DEPTH = RD_LATENCY + 2;
  localparam int unsigned PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [PW-1:0]         PTR_MAX  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] idx_q;
  logic [RD_LATENCY:0]   pipe_vld;
  logic [RD_LATENCY:0]   pipe_last;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         inflight;

  logic        head_valid;
  logic        head_last;
  logic        pop;
  logic        push;
  logic        issue;
  logic        flush;
  logic        finish;
  logic        start_frame;
  int unsigned occupancy;

  function automatic logic [ADDR_WIDTH-1:0] addr_map(input logic [ADDR_WIDTH-1:0] i);
    logic [ADDR_WIDTH-1:0] r;
    r = i;
    if (BIT_REVERSE != 0) begin
      for (int unsigned b = 0; b < ADDR_WIDTH; b++) begin
        r[b] = i[ADDR_WIDTH-1-b];
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count != '0);
  assign head_last  = fifo_last[rd_ptr];
  assign pop        = head_valid & bus.m_ready;
  assign push       = pipe_vld[RD_LATENCY];

  assign bus.m_valid = head_valid;
  assign bus.m_data  = head_valid ? fifo_data[rd_ptr] : '0;
  assign bus.m_last  = head_valid & head_last;
  assign busy        = (state_q != IDLE);

  // Every issued read not yet in the FIFO, including the one landing this cycle.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= RD_LATENCY; i++) begin
      inflight = inflight + CW'(pipe_vld[i]);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    finish      = 1'b0;
    start_frame = 1'b0;
    flush       = abort;
    occupancy   = 32'(count) + 32'(inflight) - 32'(pop);
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = READ;
          start_frame = 1'b1;
        end
      end
      READ: begin
        if (abort) begin
          state_d = IDLE;
        end else if (occupancy < FIFO_DEPTH) begin
          issue = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pop && head_last) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      idx_q       <= '0;
      bus.rd_addr <= '0;
      pipe_vld    <= '0;
      pipe_last   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      done        <= 1'b0;
    end else begin
      done <= finish;
      if (start_frame) begin
        idx_q <= '0;
      end else if (issue && (idx_q != LAST_IDX)) begin
        idx_q <= idx_q + 1'b1;
      end
      if (issue) begin
        bus.rd_addr <= addr_map(idx_q);
      end
      if (flush) begin
        pipe_vld  <= '0;
        pipe_last <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
      end else begin
        pipe_vld  <= {pipe_vld[RD_LATENCY-1:0], issue};
        pipe_last <= {pipe_last[RD_LATENCY-1:0], issue && (idx_q == LAST_IDX)};
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are gated by head_valid.
  always_ff @(posedge rd_clk) begin
    if (push && !flush && !rd_rst) begin
      fifo_data[wr_ptr] <= bus.rd_data;
      fifo_last[wr_ptr] <= pipe_last[RD_LATENCY];
    end
  end

endmodule

// File: tb/tb_fft_ram_reader.sv
// Scoreboard bench for fft_ram_reader: three instances (natural L=1,
// bit-reversed L=1, natural L=2), directed frames with ready patterns.
module tb_fft_ram_reader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;
  localparam int N = 1024;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b0;
  int   sel = 0;
  int   rmode = 0;
  int   limit = 0;
  int   cyc = 0;

  logic [2:0]    valid_v, last_v, busy_v, done_v;
  logic [DW-1:0] data_v [3];
  logic [AW-1:0] addr_v [3];

  logic [DW-1:0] ram [N];
  logic [AW-1:0] br_head [4];
  exp_t exp_q [$];

  int n_checks = 0;
  int n_fail = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L  = (g == 2) ? 2 : 1;
    localparam int unsigned BR = (g == 1) ? 1 : 0;
    fft_ram_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();
    logic [DW-1:0] ram_q [L];

    always @(posedge clk) begin
      ram_q[0] <= ram[ifc.rd_addr];
      for (int k = 1; k < L; k++) ram_q[k] <= ram_q[k-1];
    end
    assign ifc.rd_data = ram_q[L-1];
    assign ifc.m_ready = ready & (sel == g);

    fft_ram_reader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LATENCY (L),
      .BIT_REVERSE(BR)
    ) u_dut (
      .rd_clk(clk),
      .rd_rst(rst),
      .start (start & (sel == g)),
      .abort (abort & (sel == g)),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .bus   (ifc)
    );

    assign valid_v[g] = ifc.m_valid;
    assign last_v[g]  = ifc.m_last;
    assign data_v[g]  = ifc.m_data;
    assign addr_v[g]  = ifc.rd_addr;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_expected(input int s);
    logic [AW-1:0] a;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      a = AW'(k);
      if (s == 1) begin
        if (k < 4) a = br_head[k];
        else for (int b = 0; b < AW; b++) a[b] = k[AW-1-b];
      end
      e.data = ram[a];
      e.last = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a handshake seen here is taken at the following posedge.
  logic          p_v = 1'b0, p_r = 1'b0, p_l = 1'b0, p_flush = 1'b0, pend_done = 1'b0;
  logic [DW-1:0] p_dat = '0;
  always @(negedge clk) begin
    logic v, r, l, d, b;
    logic [DW-1:0] dat;
    exp_t e;
    v = valid_v[sel]; r = ready; l = last_v[sel]; d = done_v[sel]; b = busy_v[sel];
    dat = data_v[sel];
    if (pend_done) begin
      chk("done_pulse", 64'(d), 64'(1));
      chk("busy_at_done", 64'(b), 64'(0));
      pend_done = 1'b0;
      done_cnt++;
    end else if (d && !rst) begin
      chk("unexpected_done", 64'(d), 64'(0));
    end
    if (p_v && !p_r && !p_flush) begin
      chk("stall_valid", 64'(v), 64'(1));
      chk("stall_data", dat, p_dat);
      chk("stall_last", 64'(l), 64'(p_l));
    end
    if (v && r && !rst && !abort) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", dat, '1);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", dat, e.data);
        chk("beat_last", 64'(l), 64'(e.last));
        acc_cnt++;
        if (e.last) pend_done = 1'b1;
      end
    end
    p_v = v; p_r = r; p_l = l; p_dat = dat; p_flush = abort | rst;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        2:       ready = ($urandom_range(0, 99) >= 30);
        3:       ready = (acc_cnt < limit);
        default: ready = 1'b0;
      endcase
    end
  end

  task automatic run_frame(input int s, input int mode, input int lat, input int dup_at);
    int n, c0, d0;
    bit dup_done;
    dup_done = 1'b0;
    sel = s; rmode = mode; acc_cnt = 0; d0 = done_cnt;
    load_expected(s);
    step(); start = 1'b1;
    step(); start = 1'b0;
    n = 0;
    while (!valid_v[sel] && n < 20) begin step(); n++; end
    chk("first_valid_latency", 64'(n), 64'(lat + 2));
    c0 = cyc;
    n = 0;
    while (!done_v[sel] && n < 8000) begin
      if (dup_at >= 0 && !dup_done && acc_cnt >= dup_at) begin
        start = 1'b1; dup_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      step(); n++;
    end
    start = 1'b0;
    chk("done_seen", 64'(done_v[sel]), 64'(1));
    chk("busy_fall", 64'(busy_v[sel]), 64'(0));
    if (mode == 0) chk("no_bubbles", 64'(cyc - c0), 64'(N));
    repeat (6) step();
    chk("beat_count", 64'(acc_cnt), 64'(N));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    chk("done_count", 64'(done_cnt - d0), 64'(1));
  endtask

  // Stop accepting after beat index stop_beat, then abort or reset.
  task automatic run_cut(input int s, input int stop_beat, input bit use_reset);
    int n, d0;
    sel = s; rmode = 3; limit = stop_beat + 1; acc_cnt = 0; d0 = done_cnt;
    load_expected(s);
    step(); start = 1'b1;
    step(); start = 1'b0;
    n = 0;
    while (acc_cnt < limit && n < 2000) begin step(); n++; end
    chk("cut_reached", 64'(acc_cnt), 64'(limit));
    repeat (3) step();
    chk("cut_stalled_valid", 64'(valid_v[sel]), 64'(1));
    if (use_reset) rst = 1'b1; else abort = 1'b1;
    step();
    rst = 1'b0; abort = 1'b0;
    exp_q.delete();
    chk("cut_valid", 64'(valid_v[sel]), 64'(0));
    chk("cut_busy", 64'(busy_v[sel]), 64'(0));
    chk("cut_last", 64'(last_v[sel]), 64'(0));
    chk("cut_done", 64'(done_v[sel]), 64'(0));
    if (use_reset) begin
      chk("rst_data", data_v[sel], 64'(0));
      chk("rst_addr", 64'(addr_v[sel]), 64'(0));
    end
    rmode = 0;
    repeat (10) step();
    chk("cut_no_done", 64'(done_cnt - d0), 64'(0));
    chk("cut_idle_valid", 64'(valid_v[sel]), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) ram[k] = {~32'(k), 32'(k)};
    br_head[0] = 10'd0; br_head[1] = 10'd512; br_head[2] = 10'd256; br_head[3] = 10'd768;
    rst = 1'b1;
    repeat (3) step();
    for (int g = 0; g < 3; g++) begin
      chk("reset_valid", 64'(valid_v[g]), 64'(0));
      chk("reset_busy", 64'(busy_v[g]), 64'(0));
      chk("reset_done", 64'(done_v[g]), 64'(0));
      chk("reset_addr", 64'(addr_v[g]), 64'(0));
    end
    rst = 1'b0;
    step();

    run_frame(0, 0, 1, -1);   // full rate, natural order
    run_frame(0, 1, 1, -1);   // ready toggling
    run_frame(0, 2, 1, -1);   // random 30% stall
    run_frame(1, 0, 1, -1);   // bit-reversed order
    run_cut(0, 100, 1'b0);    // abort after beat 100
    run_frame(0, 0, 1, -1);   // restart after abort
    run_frame(0, 0, 1, 500);  // start while busy is ignored
    run_frame(2, 0, 2, -1);   // RD_LATENCY=2
    run_frame(2, 1, 2, -1);
    run_cut(2, 200, 1'b1);    // reset at beat 200

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
